// File: rtl/test_status_mailbox.sv
// test_status_mailbox: snoops core data-memory writes for the score mailbox store and reports done/pass, timeout or hang.
//   clk, reset           : clock, synchronous active-high reset
//   DataAdr/WriteData    : core data-memory address and write data (32b)
//   MemWrite             : core data-memory write enable
//   PC                   : core program counter (32b)
//   state                : 0=RUN 1=DONE 2=TIMEOUT 3=HUNG
//   done/pass/score      : score captured, score==MAX_SCORE, captured score
//   cycles               : RUN cycles elapsed, frozen once a verdict is reached
module test_status_mailbox #(
    parameter logic [31:0] SCORE_ADDR     = 32'd252,
    parameter logic [31:0] MAX_SCORE      = 32'd9,
    parameter int unsigned TIMEOUT_CYCLES = 160,
    parameter int unsigned HALT_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [31:0] PC,
    output logic [1:0]  state,
    output logic        done,
    output logic        pass,
    output logic [31:0] score,
    output logic [31:0] cycles
);
    typedef enum logic [1:0] {RUN, DONE, TIMEOUT, HUNG} stateT;
    stateT curState, nextState;
    logic [31:0] pcPrev, stallCnt;
    logic hit, pcSame;
    assign hit    = MemWrite && (DataAdr == SCORE_ADDR);
    assign pcSame = (PC == pcPrev);
    assign state  = curState;
    // A score store outranks a timeout or hang on the same edge.
    always_comb begin
        nextState = curState;
        if (curState == RUN)
            nextState = hit ? DONE :
                        (cycles == 32'(TIMEOUT_CYCLES - 1)) ? TIMEOUT :
                        (stallCnt == 32'(HALT_CYCLES - 1) && pcSame) ? HUNG : RUN;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            curState <= RUN;
            done     <= 1'b0;
            pass     <= 1'b0;
            score    <= '0;
            cycles   <= '0;
            pcPrev   <= '0;
            stallCnt <= '0;
        end else begin
            curState <= nextState;
            if (curState == RUN) begin
                cycles   <= (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
                pcPrev   <= PC;
                stallCnt <= pcSame ? stallCnt + 32'd1 : '0;
                if (hit) begin
                    score <= WriteData;
                    done  <= 1'b1;
                    pass  <= (WriteData == MAX_SCORE);
                end
            end
        end
    end
endmodule

// File: tb/tb_test_status_mailbox.sv
// tb_test_status_mailbox: directed self-checking bench for test_status_mailbox.
module tb_test_status_mailbox;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] DataAdr = '0, WriteData = '0, PC = '0;
    logic        MemWrite = 1'b0;
    logic [1:0]  state;
    logic        done, pass;
    logic [31:0] score, cycles;
    logic        autoPc = 1'b0;
    int          total = 0, failed = 0;

    test_status_mailbox dut (
        .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
        .MemWrite(MemWrite), .PC(PC), .state(state), .done(done), .pass(pass),
        .score(score), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // One clock edge; inputs set before the call are sampled there, outputs are read 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (autoPc) PC = PC + 32'd4;
    endtask

    task automatic doReset();
        reset = 1'b1;
        MemWrite = 1'b0;
        repeat (3) cyc();
        PC = '0;
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite = 1'b1; DataAdr = adr; WriteData = data;
        cyc();
        MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    endtask

    task automatic test_reset();
        MemWrite = 1'b1; DataAdr = 32'd252; WriteData = 32'd9;
        reset = 1'b1;
        repeat (3) cyc();
        MemWrite = 1'b0;
        total++; if (state !== 2'd0) begin failed++; $display("FAIL reset_state got %0d want 0", state); end
        total++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got %0b want 0", done); end
        total++; if (pass !== 1'b0) begin failed++; $display("FAIL reset_pass got %0b want 0", pass); end
        total++; if (score !== 32'd0) begin failed++; $display("FAIL reset_score got %0d want 0", score); end
        total++; if (cycles !== 32'd0) begin failed++; $display("FAIL reset_cycles got %0d want 0", cycles); end
        PC = '0;
        reset = 1'b0;
    endtask

    task automatic test_pass();
        doReset();
        autoPc = 1'b1;
        repeat (4) cyc();
        total++; if (state !== 2'd0 || cycles !== 32'd4) begin failed++; $display("FAIL pass_prerun got state %0d cycles %0d want 0 4", state, cycles); end
        store(32'd252, 32'd9);
        total++; if (state !== 2'd1) begin failed++; $display("FAIL pass_state got %0d want 1", state); end
        total++; if (done !== 1'b1 || pass !== 1'b1) begin failed++; $display("FAIL pass_flags got done %0b pass %0b want 1 1", done, pass); end
        total++; if (score !== 32'd9) begin failed++; $display("FAIL pass_score got %0d want 9", score); end
        total++; if (cycles !== 32'd5) begin failed++; $display("FAIL pass_cycles got %0d want 5", cycles); end
        repeat (2) cyc();
        store(32'd252, 32'd3);
        total++; if (score !== 32'd9 || pass !== 1'b1) begin failed++; $display("FAIL pass_sticky got score %0d pass %0b want 9 1", score, pass); end
        total++; if (cycles !== 32'd5 || state !== 2'd1) begin failed++; $display("FAIL pass_frozen got cycles %0d state %0d want 5 1", cycles, state); end
        autoPc = 1'b0;
    endtask

    task automatic test_fail_score();
        doReset();
        autoPc = 1'b1;
        store(32'd248, 32'd9);
        store(32'd253, 32'd9);
        MemWrite = 1'b0; DataAdr = 32'd252; WriteData = 32'd9;
        cyc();
        total++; if (state !== 2'd0 || done !== 1'b0 || score !== 32'd0) begin failed++; $display("FAIL ignore_other got state %0d done %0b score %0d want 0 0 0", state, done, score); end
        store(32'd252, 32'd7);
        total++; if (state !== 2'd1 || done !== 1'b1) begin failed++; $display("FAIL fail_state got state %0d done %0b want 1 1", state, done); end
        total++; if (pass !== 1'b0) begin failed++; $display("FAIL fail_pass got %0b want 0", pass); end
        total++; if (score !== 32'd7 || cycles !== 32'd4) begin failed++; $display("FAIL fail_score got score %0d cycles %0d want 7 4", score, cycles); end
        autoPc = 1'b0;
    endtask

    task automatic test_timeout();
        doReset();
        autoPc = 1'b1;
        repeat (159) cyc();
        total++; if (state !== 2'd0 || cycles !== 32'd159) begin failed++; $display("FAIL timeout_pre got state %0d cycles %0d want 0 159", state, cycles); end
        cyc();
        total++; if (state !== 2'd2 || cycles !== 32'd160) begin failed++; $display("FAIL timeout_entry got state %0d cycles %0d want 2 160", state, cycles); end
        total++; if (done !== 1'b0 || pass !== 1'b0 || score !== 32'd0) begin failed++; $display("FAIL timeout_flags got done %0b pass %0b score %0d want 0 0 0", done, pass, score); end
        store(32'd252, 32'd9);
        cyc();
        total++; if (state !== 2'd2 || cycles !== 32'd160 || score !== 32'd0) begin failed++; $display("FAIL timeout_sticky got state %0d cycles %0d score %0d want 2 160 0", state, cycles, score); end
        autoPc = 1'b0;
    endtask

    task automatic test_hang();
        doReset();
        autoPc = 1'b1;
        repeat (9) cyc();
        autoPc = 1'b0;
        PC = 32'h40;
        repeat (8) cyc();
        total++; if (state !== 2'd0 || cycles !== 32'd17) begin failed++; $display("FAIL hang_pre got state %0d cycles %0d want 0 17", state, cycles); end
        cyc();
        total++; if (state !== 2'd3 || cycles !== 32'd18) begin failed++; $display("FAIL hang_entry got state %0d cycles %0d want 3 18", state, cycles); end
        repeat (3) cyc();
        total++; if (state !== 2'd3 || cycles !== 32'd18 || pass !== 1'b0) begin failed++; $display("FAIL hang_sticky got state %0d cycles %0d pass %0b want 3 18 0", state, cycles, pass); end
    endtask

    task automatic test_hit_vs_timeout();
        doReset();
        autoPc = 1'b1;
        repeat (159) cyc();
        store(32'd252, 32'd9);
        total++; if (state !== 2'd1 || cycles !== 32'd160) begin failed++; $display("FAIL race_state got state %0d cycles %0d want 1 160", state, cycles); end
        total++; if (pass !== 1'b1 || score !== 32'd9) begin failed++; $display("FAIL race_pass got pass %0b score %0d want 1 9", pass, score); end
        autoPc = 1'b0;
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        cyc();
        total++; if (state !== 2'd0 || done !== 1'b0 || pass !== 1'b0 || score !== 32'd0 || cycles !== 32'd0) begin failed++; $display("FAIL rst_done got state %0d done %0b pass %0b score %0d cycles %0d want all 0", state, done, pass, score, cycles); end
        PC = '0;
        reset = 1'b0;
        autoPc = 1'b1;
        repeat (49) cyc();
        total++; if (cycles !== 32'd49) begin failed++; $display("FAIL rerun_cycles got %0d want 49", cycles); end
        reset = 1'b1;
        cyc();
        total++; if (state !== 2'd0 || cycles !== 32'd0) begin failed++; $display("FAIL rst_mid got state %0d cycles %0d want 0 0", state, cycles); end
        PC = '0;
        reset = 1'b0;
        repeat (2) cyc();
        store(32'd252, 32'd9);
        total++; if (state !== 2'd1 || pass !== 1'b1 || score !== 32'd9 || cycles !== 32'd3) begin failed++; $display("FAIL rescore got state %0d pass %0b score %0d cycles %0d want 1 1 9 3", state, pass, score, cycles); end
        autoPc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_score();
        test_timeout();
        test_hang();
        test_hit_vs_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end
endmodule
